// File: rtl/score_conversion_pkg.sv
// Shared definitions for the rhythm-game score conversion block:
// judgement encodings, point values, bonus threshold and saturation limits.
package score_conversion_pkg;

    // Judgement encoding delivered by each lane's hit detector
    typedef enum logic [1:0] {
        PERFECT = 2'b00,
        GOOD    = 2'b01,
        MISS    = 2'b10,
        NO_NOTE = 2'b11
    } judgement_e;

    // Base points per lane and the per-hit bonus once the combo is long enough
    localparam logic [7:0] PTS_PERFECT = 8'd100;
    localparam logic [7:0] PTS_GOOD    = 8'd50;
    localparam logic [7:0] PTS_BONUS   = 8'd10;

    // Combo length (before the event) at which every hit lane earns the bonus
    localparam logic [7:0] COMBO_BONUS_THRESHOLD = 8'd10;

    // Saturation ceilings for the accumulators
    localparam logic [15:0] SCORE_MAX = 16'hFFFF;
    localparam logic [7:0]  COMBO_MAX = 8'hFF;

    // Add event points to the running score, clamping at SCORE_MAX
    function automatic logic [15:0] score_sat_add(input logic [15:0] score_in,
                                                  input logic [8:0]  points_in);
        logic [16:0] sum;
        sum = {1'b0, score_in} + {8'b0, points_in};
        if (sum[16]) begin
            return SCORE_MAX;
        end
        return sum[15:0];
    endfunction

    // Add hit lanes to the combo counter, clamping at COMBO_MAX
    function automatic logic [7:0] combo_sat_add(input logic [7:0] combo_in,
                                                 input logic [1:0] hits_in);
        logic [8:0] sum;
        sum = {1'b0, combo_in} + {7'b0, hits_in};
        if (sum[8]) begin
            return COMBO_MAX;
        end
        return sum[7:0];
    endfunction

endpackage : score_conversion_pkg

// File: rtl/score_conversion_lane_points.sv
// Converts one lane's judgement into points (with optional combo bonus)
// and a hit flag. Purely combinational; one instance per lane.
module lane_points
    import score_conversion_pkg::*;
(
    input  logic [1:0] judgement,
    input  logic       bonus_en,
    output logic [7:0] points,
    output logic       hit
);

    // Map judgement to base points; hits additionally earn the bonus when enabled
    always_comb begin
        points = 8'd0;
        hit    = 1'b0;
        case (judgement)
            PERFECT: begin
                hit    = 1'b1;
                points = bonus_en ? (PTS_PERFECT + PTS_BONUS) : PTS_PERFECT;
            end
            GOOD: begin
                hit    = 1'b1;
                points = bonus_en ? (PTS_GOOD + PTS_BONUS) : PTS_GOOD;
            end
            default: begin
                hit    = 1'b0;
                points = 8'd0;
            end
        endcase
    end

endmodule : lane_points

// File: rtl/score_conversion.sv
// Score and combo accumulator for a two-lane rhythm game. Each valid judging
// event adds both lanes' points to a saturating 16-bit score and updates a
// saturating 8-bit combo counter; a MISS on either lane breaks the combo.
module score_conversion
    import score_conversion_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        judgement_valid,
    input  logic [1:0]  judgement_up,
    input  logic [1:0]  judgement_down,
    output logic [15:0] score,
    output logic [7:0]  combo
);

    logic [15:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d;

    logic        bonus_en;
    logic [7:0]  up_points, down_points;
    logic        up_hit, down_hit;
    logic [8:0]  event_points;
    logic [1:0]  hit_count;
    logic        any_miss;

    // Bonus decision uses the combo as it stood before this event
    assign bonus_en = (combo_q >= COMBO_BONUS_THRESHOLD);

    lane_points u_lane_up (
        .judgement (judgement_up),
        .bonus_en  (bonus_en),
        .points    (up_points),
        .hit       (up_hit)
    );

    lane_points u_lane_down (
        .judgement (judgement_down),
        .bonus_en  (bonus_en),
        .points    (down_points),
        .hit       (down_hit)
    );

    // Combine both lanes: total points, number of hits, and combo-break flag
    always_comb begin
        event_points = {1'b0, up_points} + {1'b0, down_points};
        hit_count    = {1'b0, up_hit} + {1'b0, down_hit};
        any_miss     = (judgement_up == MISS) || (judgement_down == MISS);
    end

    // Next-state for score and combo; idle cycles simply hold
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        if (judgement_valid) begin
            score_d = score_sat_add(score_q, event_points);
            combo_d = any_miss ? 8'd0 : combo_sat_add(combo_q, hit_count);
        end
    end

    // State registers; reset clears immediately and discards any pending event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= 16'h0000;
            combo_q <= 8'h00;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign score = score_q;
    assign combo = combo_q;

endmodule : score_conversion

// File: tb/tb_score_conversion.sv
// Directed bench for score_conversion: walks the scoring, bonus, combo-break,
// saturation, idle-hold and asynchronous-reset behaviour with fixed vectors.
module tb_score_conversion;

    localparam logic [1:0] JP = 2'b00;  // PERFECT
    localparam logic [1:0] JG = 2'b01;  // GOOD
    localparam logic [1:0] JM = 2'b10;  // MISS
    localparam logic [1:0] JN = 2'b11;  // NO_NOTE

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        judgement_valid = 1'b0;
    logic [1:0]  judgement_up = 2'b11;
    logic [1:0]  judgement_down = 2'b11;
    logic [15:0] score;
    logic [7:0]  combo;

    int n_checks = 0;
    int n_fail   = 0;

    score_conversion dut (
        .clk             (clk),
        .rst             (rst),
        .judgement_valid (judgement_valid),
        .judgement_up    (judgement_up),
        .judgement_down  (judgement_down),
        .score           (score),
        .combo           (combo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("%s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_both(input string tag, input int exp_score, input int exp_combo);
        check({tag, ".score"}, int'(score), exp_score);
        check({tag, ".combo"}, int'(combo), exp_combo);
        $display("step %-14s up/down=%0d/%0d score=%0d combo=%0d", tag,
                 judgement_up, judgement_down, score, combo);
    endtask

    // One valid event: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic [1:0] up, input logic [1:0] down);
        @(negedge clk);
        judgement_valid = 1'b1;
        judgement_up    = up;
        judgement_down  = down;
        @(posedge clk);
        #1;
        judgement_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_both("reset", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic scoring sequence
        step(JP, JN); check_both("p_nn", 100, 1);
        step(JG, JN); check_both("g_nn", 150, 2);
        step(JG, JP); check_both("g_p", 300, 4);
        step(JP, JP); check_both("p_p_a", 500, 6);

        // Bonus threshold: uses combo before the event
        step(JP, JP); check_both("p_p_c6", 700, 8);
        step(JP, JP); check_both("p_p_c8", 900, 10);
        step(JP, JP); check_both("p_p_c10", 1120, 12);

        // MISS breaks combo but the other lane still scores with bonus
        step(JP, JM); check_both("p_miss", 1230, 0);

        // NO_NOTE on both lanes is a no-op even with valid high
        step(JN, JN); check_both("nn_nn", 1230, 0);
        step(JM, JG); check_both("miss_g", 1280, 0);

        // Idle cycles with changing judgements must not change anything
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            judgement_valid = 1'b0;
            judgement_up    = 2'($urandom_range(0, 2));
            judgement_down  = 2'($urandom_range(0, 2));
            @(posedge clk);
            #1;
            check_both($sformatf("idle%0d", i), 1280, 0);
        end

        // Asynchronous reset mid-event: clears without a clock edge, event dropped
        step(JG, JG); check_both("pre_rst", 1380, 2);
        @(negedge clk);
        judgement_valid = 1'b1;
        judgement_up    = JP;
        judgement_down  = JP;
        #2 rst = 1'b1;
        #1;
        check_both("rst_async", 0, 0);
        @(posedge clk);
        #1;
        judgement_valid = 1'b0;
        check_both("rst_hold", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(JP, JN); check_both("post_rst", 100, 1);

        // Clean reset, then preload score to 65500 with combo 10
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_both("rst2", 0, 0);
        for (int i = 0; i < 645; i++) step(JP, JM);
        check_both("preload_a", 64500, 0);
        for (int i = 0; i < 5; i++) step(JP, JP);
        check_both("preload_b", 65500, 10);

        // Score saturation on a bonus-eligible event
        step(JP, JP); check_both("score_sat", 65535, 12);
        step(JG, JN); check_both("score_hold", 65535, 13);

        // Combo climbs to exactly 255, then saturates instead of wrapping
        for (int i = 0; i < 121; i++) step(JP, JP);
        check_both("combo_255", 65535, 255);
        step(JP, JP); check_both("combo_sat", 65535, 255);
        step(JG, JN); check_both("combo_sat1", 65535, 255);
        step(JN, JM); check_both("combo_brk", 65535, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_score_conversion

// File: doc/score_conversion.md
SCORE_CONVERSION -- requirements
Module: score_conversion

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 judgement_valid  input  1  high for one clk: both judgement inputs form one judging event.
REQ-005 judgement_up  input  2  upper-lane judgement: 2'b00 PERFECT, 2'b01 GOOD, 2'b10 MISS, 2'b11 NO_NOTE.
REQ-006 judgement_down  input  2  lower-lane judgement, same encoding as judgement_up.
REQ-007 score  output  16  accumulated total score, registered.
REQ-008 combo  output  8  current consecutive-hit count, registered.

Function
REQ-009 Each lane SHALL be converted to base points independently: PERFECT = 100, GOOD = 50, MISS = 0, NO_NOTE = 0.
REQ-010 A lane SHALL count as a hit when its judgement is PERFECT or GOOD.
REQ-011 If combo is >= 10 before the event, each hit lane SHALL earn an extra 10 points.
REQ-012 Event points SHALL be the sum of both lanes' points, including any bonus; the maximum is 220 points per event.
REQ-013 On a clk edge with judgement_valid = 1, score SHALL become score + event points.
- The addition saturates at 16'hFFFF; score never wraps.
REQ-014 On a clk edge with judgement_valid = 1, combo SHALL update as follows:
- If either lane is MISS, combo becomes 0, even if the other lane is a hit.
- Otherwise, combo increases by the number of hit lanes (0, 1 or 2) and saturates at 255.
REQ-015 NO_NOTE on both lanes SHALL leave score and combo unchanged.
REQ-016 With judgement_valid = 0, score and combo SHALL hold their values; judgement inputs are ignored.
REQ-017 Latency SHALL be one cycle: updated outputs are visible after the clk edge that samples judgement_valid = 1.
- Back-to-back valid events are accepted every cycle.
REQ-018 The combo-bonus decision SHALL use the pre-update combo of the same event.

Reset
REQ-019 While rst is high, score SHALL be 16'h0000 and combo SHALL be 8'h00, immediately and independent of clk.
REQ-020 An event in progress when rst asserts SHALL be discarded.
REQ-021 After rst deasserts, the first valid event SHALL be processed on the next clk edge.

Structure
REQ-022 A shared package SHALL hold:
- the judgement encodings: PERFECT, GOOD, MISS, NO_NOTE;
- the point constants: 100, 50, and bonus 10;
- the combo bonus threshold: 10.
REQ-023 One sub-module, lane_points, SHALL convert a single judgement plus a bonus-enable into 8-bit points and a hit flag.
- It is instantiated twice, once per lane.
- Accumulation and combo logic remain in score_conversion.

Verification
REQ-024 Reset, then one valid event with up = PERFECT, down = NO_NOTE -> score = 100, combo = 1.
REQ-025 Continue with a valid sequence, checking the result after each event:
- up = GOOD, down = NO_NOTE -> score = 150, combo = 2;
- up = GOOD, down = PERFECT -> score = 300, combo = 4;
- up = PERFECT, down = PERFECT -> score = 500, combo = 6.
REQ-026 Starting at combo = 6, apply two PERFECT/PERFECT events:
- first event -> score +200, combo = 8;
- second event (pre-update combo is 8, no bonus) -> score +200, combo = 10;
- a third such event (pre-update combo is 10) -> score +220, combo = 12.
REQ-027 At combo = 12, apply up = PERFECT, down = MISS -> score +110, combo = 0.
REQ-028 Preload score = 65500 via a sequence, then apply a bonus-eligible PERFECT/PERFECT event -> score = 65535 (saturated).
REQ-029 Hold judgement_valid = 0 with changing judgements for 5 cycles -> outputs unchanged.
- Assert rst mid-sequence -> score = 0 and combo = 0 immediately, without waiting for a clk edge.
